// File: rtl/fetch_stage_pkg.sv
// Constants shared by the fetch stage and the ID decoder: FSM states, the NOP
// encoding, the sequential PC step and the instruction field positions.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam int          PC_INCR    = 4;

    localparam int          OPCODE_MSB = 31;
    localparam int          OPCODE_LSB = 26;
    localparam int          FUNC_MSB   = 5;
    localparam int          FUNC_LSB   = 0;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold, and an idle
// cycle without hold inserts a bubble (valid=0, NOP instruction).
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              flush_i,
    input  logic              hold_i,
    input  logic [31:0]       instr_i,
    input  logic [ADDR_W-1:0] pc4_i,
    output logic              valid_o,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] pc4_o
);

    logic              valid_q;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] pc4_q;

    // pc4 is only meaningful while valid, so flushes and bubbles leave it alone
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
        end else if (!hold_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding imem requests, a one-entry hold
// buffer for responses that land during a stall, and redirect/squash handling.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_rvalid,
    output logic              ifid_valid,
    output logic [31:0]       ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc4,
    output logic [5:0]        ifid_opcode,
    output logic [5:0]        ifid_func
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              discard_q;
    logic              holdValid_q;
    logic [31:0]       holdInstr_q;
    logic [ADDR_W-1:0] holdPc4_q;

    logic [ADDR_W-1:0] pcPlus4;
    logic [ADDR_W-1:0] redirectAligned;
    logic              accept;
    logic              reqIssue;
    logic              outstandingAfter;
    logic              ifidLoad;
    logic [31:0]       ifidInstrIn;
    logic [ADDR_W-1:0] ifidPc4In;

    assign pcPlus4         = pc_q + ADDR_W'(PC_INCR);
    assign redirectAligned = redirect_pc & ~ADDR_W'(3);
    assign accept          = (state_q == ST_WAIT) && imem_rvalid && !discard_q;

    // Back-to-back request on an accepted response keeps 1-cycle memory at full rate
    assign reqIssue = !rst && (((state_q == ST_REQ) && !holdValid_q) ||
                               (accept && !stall && !redirect));
    assign outstandingAfter = ((state_q == ST_WAIT) && !imem_rvalid) || reqIssue;

    assign imem_req  = reqIssue;
    assign imem_addr = (state_q == ST_REQ) ? pc_q : pcPlus4;

    assign ifidLoad    = !stall && (accept || ((state_q == ST_HOLD) && holdValid_q));
    assign ifidInstrIn = (state_q == ST_HOLD) ? holdInstr_q : imem_rdata;
    assign ifidPc4In   = (state_q == ST_HOLD) ? holdPc4_q : pcPlus4;

    // A redirect that leaves a response in flight marks it for discard
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_REQ;
            pc_q        <= RESET_PC;
            discard_q   <= 1'b0;
            holdValid_q <= 1'b0;
            holdInstr_q <= NOP_INSTR;
            holdPc4_q   <= '0;
        end else if (redirect) begin
            pc_q        <= redirectAligned;
            holdValid_q <= 1'b0;
            holdInstr_q <= NOP_INSTR;
            if (outstandingAfter) begin
                discard_q <= 1'b1;
                state_q   <= ST_WAIT;
            end else begin
                discard_q <= 1'b0;
                state_q   <= ST_REQ;
            end
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (reqIssue) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (discard_q) begin
                            discard_q <= 1'b0;
                            state_q   <= ST_REQ;
                        end else begin
                            pc_q <= pcPlus4;
                            if (stall) begin
                                holdValid_q <= 1'b1;
                                holdInstr_q <= imem_rdata;
                                holdPc4_q   <= pcPlus4;
                                state_q     <= ST_HOLD;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        holdValid_q <= 1'b0;
                        state_q     <= ST_REQ;
                    end
                end
                default: state_q <= ST_REQ;
            endcase
        end
    end

    fetch_stage_if_id_reg #(
        .ADDR_W (ADDR_W)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ifidLoad),
        .flush_i (redirect),
        .hold_i  (stall),
        .instr_i (ifidInstrIn),
        .pc4_i   (ifidPc4In),
        .valid_o (ifid_valid),
        .instr_o (ifid_instr),
        .pc4_o   (ifid_pc4)
    );

    assign ifid_opcode = ifid_instr[OPCODE_MSB:OPCODE_LSB];
    assign ifid_func   = ifid_instr[FUNC_MSB:FUNC_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed pipeline scenarios plus a randomized
// stall/redirect/latency stream checked against an in-order fetch model.
module tb_fetch_stage;

    localparam int          ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk         = 1'b0;
    logic        rst         = 1'b1;
    logic        stall       = 1'b0;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata  = '0;
    logic        imem_rvalid = 1'b0;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic [5:0]  ifid_opcode;
    logic [5:0]  ifid_func;

    int total = 0;
    int bad   = 0;

    int          memLat       = 1;
    bit          randLat      = 1'b0;
    bit          overrideEn   = 1'b0;
    logic [31:0] overrideAddr = '0;
    logic [31:0] overrideData = '0;
    bit          pendValid    = 1'b0;
    logic [31:0] pendAddr     = '0;
    int          pendCnt      = 0;
    int          overlapErr   = 0;
    int          misalignErr  = 0;
    logic [31:0] reqLog[$];

    fetch_stage #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_rvalid (imem_rvalid),
        .ifid_valid  (ifid_valid),
        .ifid_instr  (ifid_instr),
        .ifid_pc4    (ifid_pc4),
        .ifid_opcode (ifid_opcode),
        .ifid_func   (ifid_func)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (overrideEn && a == overrideAddr) ? overrideData : (a ^ 32'hA5A5_0000);
    endfunction

    // Instruction memory: in-order, configurable latency, cleared by the shared reset
    always @(posedge clk) begin
        logic        rv;
        logic [31:0] rd;
        int          lat;
        bit          wasPend;
        rv = 1'b0;
        rd = 32'hDEAD_BEEF;
        if (rst) begin
            pendValid = 1'b0;
        end else begin
            wasPend = pendValid;
            if (pendValid) begin
                pendCnt = pendCnt - 1;
                if (pendCnt == 0) begin
                    rv        = 1'b1;
                    rd        = memWord(pendAddr);
                    pendValid = 1'b0;
                end
            end
            if (imem_req) begin
                reqLog.push_back(imem_addr);
                if (imem_addr[1:0] != 2'b00) misalignErr++;
                if (wasPend) overlapErr++;
                lat = randLat ? int'($urandom_range(1, 3)) : memLat;
                if (lat <= 1) begin
                    rv = 1'b1;
                    rd = memWord(imem_addr);
                end else begin
                    pendValid = 1'b1;
                    pendAddr  = imem_addr;
                    pendCnt   = lat - 1;
                end
            end
        end
        imem_rvalid <= rv;
        imem_rdata  <= rd;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        tick();
        tick();
        rst = 1'b0;
        reqLog.delete();
    endtask

    task automatic test_reset();
        stall    = 1'b0;
        redirect = 1'b0;
        rst      = 1'b1;
        tick();
        #1;
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_req: got %b expected 0", imem_req);
        end
        tick();
        total++;
        if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc4 !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_ifid: got v=%b i=%h pc4=%h expected 0/0/0",
                     ifid_valid, ifid_instr, ifid_pc4);
        end
        total++;
        if (ifid_opcode !== 6'h0 || ifid_func !== 6'h0) begin
            bad++;
            $display("[TB] FAIL reset_fields: got op=%h fn=%h expected 00/00", ifid_opcode, ifid_func);
        end
        rst = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            bad++;
            $display("[TB] FAIL reset_first_req: got req=%b addr=%h expected 1/%h",
                     imem_req, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        memLat     = 1;
        randLat    = 1'b0;
        overrideEn = 1'b0;
        do_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'(4 * (i + 1)) ||
                ifid_instr !== memWord(32'(4 * i))) begin
                bad++;
                $display("[TB] FAIL seq_ifid[%0d]: got v=%b i=%h pc4=%h expected 1/%h/%h", i,
                         ifid_valid, ifid_instr, ifid_pc4, memWord(32'(4 * i)), 32'(4 * (i + 1)));
            end
        end
        total++;
        if (reqLog.size() < 3 || reqLog[0] !== 32'h0 || reqLog[1] !== 32'h4 || reqLog[2] !== 32'h8) begin
            bad++;
            $display("[TB] FAIL seq_addrs: got %0d requests expected 0,4,8 consecutively", reqLog.size());
        end
    endtask

    task automatic test_stall();
        bit found;
        memLat = 1;
        do_reset();
        tick();
        tick();
        tick();
        stall = 1'b1;
        reqLog.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'h8 || ifid_instr !== memWord(32'h4)) begin
                bad++;
                $display("[TB] FAIL stall_hold[%0d]: got v=%b i=%h pc4=%h expected 1/%h/8", i,
                         ifid_valid, ifid_instr, ifid_pc4, memWord(32'h4));
            end
        end
        stall = 1'b0;
        tick();
        total++;
        if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'hC || ifid_instr !== memWord(32'h8)) begin
            bad++;
            $display("[TB] FAIL stall_release: got v=%b i=%h pc4=%h expected 1/%h/c",
                     ifid_valid, ifid_instr, ifid_pc4, memWord(32'h8));
        end
        total++;
        if (reqLog.size() != 0) begin
            bad++;
            $display("[TB] FAIL stall_noreq: got %0d requests expected 0", reqLog.size());
        end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (ifid_valid === 1'b1) found = 1'b1;
        end
        total++;
        if (!found || ifid_pc4 !== 32'h10 || ifid_instr !== memWord(32'hC)) begin
            bad++;
            $display("[TB] FAIL stall_next: got found=%b pc4=%h i=%h expected 1/10/%h",
                     found, ifid_pc4, ifid_instr, memWord(32'hC));
        end
        total++;
        if (reqLog.size() == 0 || reqLog[0] !== 32'hC) begin
            bad++;
            $display("[TB] FAIL stall_next_addr: got %0d requests expected first addr c", reqLog.size());
        end
    endtask

    task automatic test_redirect_latency();
        bit found;
        memLat = 3;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (reqLog.size() >= 3) found = 1'b1;
        end
        total++;
        if (!found || reqLog[2] !== 32'h8) begin
            bad++;
            $display("[TB] FAIL lat3_req8: got found=%b expected third request to 8", found);
        end
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        reqLog.delete();
        tick();
        redirect = 1'b0;
        total++;
        if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin
            bad++;
            $display("[TB] FAIL redir_flush: got v=%b i=%h expected 0/0", ifid_valid, ifid_instr);
        end
        found = 1'b0;
        for (int i = 0; i < 25 && !found; i++) begin
            tick();
            if (ifid_valid === 1'b1) found = 1'b1;
        end
        total++;
        if (!found || ifid_pc4 !== 32'h104 || ifid_instr !== memWord(32'h100)) begin
            bad++;
            $display("[TB] FAIL redir_target: got found=%b pc4=%h i=%h expected 1/104/%h",
                     found, ifid_pc4, ifid_instr, memWord(32'h100));
        end
        total++;
        if (reqLog.size() == 0 || reqLog[0] !== 32'h100) begin
            bad++;
            $display("[TB] FAIL redir_addr: got %0d requests expected first addr 100", reqLog.size());
        end
    endtask

    task automatic test_redirect_in_hold();
        bit found;
        memLat = 1;
        do_reset();
        tick();
        tick();
        tick();
        stall = 1'b1;
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        reqLog.delete();
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        total++;
        if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin
            bad++;
            $display("[TB] FAIL hold_redir_flush: got v=%b i=%h expected 0/0", ifid_valid, ifid_instr);
        end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (ifid_valid === 1'b1) found = 1'b1;
        end
        total++;
        if (!found || ifid_pc4 !== 32'h44 || ifid_instr !== memWord(32'h40)) begin
            bad++;
            $display("[TB] FAIL hold_redir_target: got found=%b pc4=%h i=%h expected 1/44/%h",
                     found, ifid_pc4, ifid_instr, memWord(32'h40));
        end
        total++;
        if (reqLog.size() == 0 || reqLog[0] !== 32'h40) begin
            bad++;
            $display("[TB] FAIL hold_redir_addr: got %0d requests expected first addr 40", reqLog.size());
        end
    endtask

    task automatic test_fields_and_wrap();
        bit found;
        memLat       = 1;
        overrideEn   = 1'b1;
        overrideAddr = 32'h200;
        overrideData = 32'h0085_1020;
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (ifid_valid === 1'b1) found = 1'b1;
        end
        total++;
        if (!found || ifid_instr !== 32'h0085_1020 || ifid_opcode !== 6'h00 ||
            ifid_func !== 6'h20 || ifid_pc4 !== 32'h204) begin
            bad++;
            $display("[TB] FAIL fields: got i=%h op=%h fn=%h pc4=%h expected 00851020/00/20/204",
                     ifid_instr, ifid_opcode, ifid_func, ifid_pc4);
        end
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        reqLog.delete();
        tick();
        redirect = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (ifid_valid === 1'b1) found = 1'b1;
        end
        total++;
        if (!found || ifid_pc4 !== 32'h0 || ifid_instr !== memWord(32'hFFFF_FFFC)) begin
            bad++;
            $display("[TB] FAIL wrap_top: got pc4=%h i=%h expected 0/%h",
                     ifid_pc4, ifid_instr, memWord(32'hFFFF_FFFC));
        end
        tick();
        total++;
        if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'h4 || ifid_instr !== memWord(32'h0)) begin
            bad++;
            $display("[TB] FAIL wrap_next: got v=%b pc4=%h i=%h expected 1/4/%h",
                     ifid_valid, ifid_pc4, ifid_instr, memWord(32'h0));
        end
        total++;
        if (reqLog.size() < 2 || reqLog[0] !== 32'hFFFF_FFFC || reqLog[1] !== 32'h0) begin
            bad++;
            $display("[TB] FAIL wrap_addr: got %0d requests expected fffffffc then 0", reqLog.size());
        end
        overrideEn = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        bit found;
        memLat = 2;
        do_reset();
        tick();
        tick();
        tick();
        total++;
        if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'h4) begin
            bad++;
            $display("[TB] FAIL rstwait_pre: got v=%b pc4=%h expected 1/4", ifid_valid, ifid_pc4);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        reqLog.delete();
        #1;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC || ifid_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rstwait_post: got req=%b addr=%h v=%b expected 1/%h/0",
                     imem_req, imem_addr, ifid_valid, RESET_PC);
        end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (ifid_valid === 1'b1) found = 1'b1;
        end
        total++;
        if (!found || ifid_pc4 !== RESET_PC + 32'd4 || ifid_instr !== memWord(RESET_PC)) begin
            bad++;
            $display("[TB] FAIL rstwait_first: got found=%b pc4=%h i=%h expected 1/%h/%h",
                     found, ifid_pc4, ifid_instr, RESET_PC + 32'd4, memWord(RESET_PC));
        end
    endtask

    // The model only tracks which address the decoder should see next
    task automatic test_random_stream();
        logic [31:0] expNext;
        logic [31:0] want;
        logic [31:0] lastTarget;
        logic [31:0] prevInstr;
        logic [31:0] prevPc4;
        logic        prevValid;
        bit          lastStall;
        bit          lastRedirect;
        int          delivered;
        memLat     = 1;
        randLat    = 1'b1;
        overrideEn = 1'b0;
        do_reset();
        overlapErr   = 0;
        misalignErr  = 0;
        expNext      = RESET_PC;
        lastStall    = 1'b0;
        lastRedirect = 1'b0;
        lastTarget   = '0;
        prevValid    = ifid_valid;
        prevInstr    = ifid_instr;
        prevPc4      = ifid_pc4;
        delivered    = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (lastRedirect) begin
                total++;
                if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin
                    bad++;
                    $display("[TB] FAIL rnd_flush@%0d: got v=%b i=%h expected 0/0", c, ifid_valid, ifid_instr);
                end
                expNext = lastTarget & 32'hFFFF_FFFC;
            end else if (lastStall) begin
                total++;
                if (ifid_valid !== prevValid || ifid_instr !== prevInstr || ifid_pc4 !== prevPc4) begin
                    bad++;
                    $display("[TB] FAIL rnd_hold@%0d: got v=%b i=%h pc4=%h expected %b/%h/%h", c,
                             ifid_valid, ifid_instr, ifid_pc4, prevValid, prevInstr, prevPc4);
                end
            end else if (ifid_valid === 1'b1) begin
                want = memWord(expNext);
                total++;
                if (ifid_pc4 !== expNext + 32'd4 || ifid_instr !== want ||
                    ifid_opcode !== want[31:26] || ifid_func !== want[5:0]) begin
                    bad++;
                    $display("[TB] FAIL rnd_deliver@%0d: got pc4=%h i=%h op=%h fn=%h expected %h/%h/%h/%h", c,
                             ifid_pc4, ifid_instr, ifid_opcode, ifid_func,
                             expNext + 32'd4, want, want[31:26], want[5:0]);
                end
                expNext = expNext + 32'd4;
                delivered++;
            end else begin
                total++;
                if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin
                    bad++;
                    $display("[TB] FAIL rnd_bubble@%0d: got v=%b i=%h expected 0/0", c, ifid_valid, ifid_instr);
                end
            end
            prevValid    = ifid_valid;
            prevInstr    = ifid_instr;
            prevPc4      = ifid_pc4;
            lastStall    = ($urandom_range(0, 3) == 0);
            lastRedirect = ($urandom_range(0, 19) == 0);
            lastTarget   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8
                                                       : 32'h1000 + 32'($urandom_range(0, 255));
            stall        = lastStall;
            redirect     = lastRedirect;
            redirect_pc  = lastTarget;
        end
        stall    = 1'b0;
        redirect = 1'b0;
        randLat  = 1'b0;
        total++;
        if (overlapErr != 0) begin
            bad++;
            $display("[TB] FAIL rnd_single_outstanding: got %0d overlaps expected 0", overlapErr);
        end
        total++;
        if (misalignErr != 0) begin
            bad++;
            $display("[TB] FAIL rnd_aligned: got %0d misaligned requests expected 0", misalignErr);
        end
        total++;
        if (delivered < 200) begin
            bad++;
            $display("[TB] FAIL rnd_progress: got %0d deliveries expected at least 200", delivered);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_latency();
        test_redirect_in_hold();
        test_fields_and_wrap();
        test_reset_in_wait();
        test_random_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
